// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: drives PC requests to the ICache and pushes
// returned 8-byte aligned instruction pairs into the instruction buffer.
module inst_fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'hBFC00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_redirect_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              buffer_full_i,
  output logic              icache_req_o,
  output logic [ADDR_W-1:0] icache_addr_o,
  input  logic              icache_addr_ok_i,
  input  logic              icache_data_ok_i,
  input  logic [31:0]       icache_inst1_i,
  input  logic [31:0]       icache_inst2_i,
  output logic [31:0]       inst1_o,
  output logic [31:0]       inst2_o,
  output logic [ADDR_W-1:0] inst1_addr_o,
  output logic [ADDR_W-1:0] inst2_addr_o,
  output logic              inst1_valid_o,
  output logic              inst2_valid_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [31:0]       inst1_q, inst1_d, inst2_q, inst2_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic              v1_q, v1_d, v2_q, v2_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] req_base;

  assign redirect = flush_i | branch_redirect_i;
  assign target   = flush_i ? flush_pc_i : branch_target_i;
  assign req_base = {req_pc_q[ADDR_W-1:3], 3'b000};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    inst1_d  = inst1_q;
    inst2_d  = inst2_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    v1_d     = 1'b0;
    v2_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!buffer_full_i) state_d = REQ;
      end
      REQ: begin
        if (icache_addr_ok_i) begin
          req_pc_d = pc_q;
          state_d  = redirect ? DISCARD : WAIT;
        end
      end
      WAIT: begin
        if (icache_data_ok_i) begin
          if (redirect) begin
            state_d = REQ;
          end else begin
            inst1_d = icache_inst1_i;
            inst2_d = icache_inst2_i;
            addr1_d = req_base;
            addr2_d = req_base + ADDR_W'(4);
            v1_d    = ~req_pc_q[2];
            v2_d    = 1'b1;
            pc_d    = req_base + ADDR_W'(8);
            state_d = buffer_full_i ? IDLE : REQ;
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (icache_data_ok_i) state_d = buffer_full_i ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase

    // A redirect retargets the PC in every state and wipes the push registers.
    if (redirect) begin
      pc_d    = target;
      inst1_d = '0;
      inst2_d = '0;
      addr1_d = '0;
      addr2_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      inst1_q  <= '0;
      inst2_q  <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      inst1_q  <= inst1_d;
      inst2_q  <= inst2_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
    end
  end

  // The address bus is only meaningful alongside the request, so it idles at zero.
  assign icache_req_o  = (state_q == REQ);
  assign icache_addr_o = icache_req_o ? {pc_q[ADDR_W-1:3], 3'b000} : '0;
  assign inst1_o       = inst1_q;
  assign inst2_o       = inst2_q;
  assign inst1_addr_o  = addr1_q;
  assign inst2_addr_o  = addr2_q;
  assign inst1_valid_o = v1_q;
  assign inst2_valid_o = v2_q;

endmodule
